// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state and owner enums plus default widths and timing for mem_port_arbiter
package mem_arb_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_MEM_LAT = 2;
  localparam int DEF_STARVE_MAX = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/data request-response handshakes and memory macro bus; slave = arbiter, master = stages + memory
interface mem_port_arbiter_if import mem_arb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_wstrb;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  if_req_valid, if_addr, if_flush, d_req_valid, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
    output if_req_ready, if_rsp_valid, if_rdata, d_req_ready, d_rsp_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
  modport master (
    output if_req_valid, if_addr, if_flush, d_req_valid, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rdata, d_req_ready, d_rsp_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: counts data grants made while fetch waits (clk, rst, d_grant, if_grant, if_valid in; override out when count hits STARVE_MAX)
module mem_arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_grant,
  input  logic if_grant,
  input  logic if_valid,
  output logic override
);
  logic [3:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (if_grant) cnt <= '0;
    else if (d_grant && if_valid) cnt <= cnt + 4'd1;
  end
  assign override = cnt == 4'(STARVE_MAX);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between fetch and data ports (clk, rst, bus: mem_port_arbiter_if.slave); MEM_ARB_STARVE_EN enables fetch anti-starvation
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  if (DATA_W != 32 || MEM_LAT < 1 || MEM_LAT > 7 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_cfg
    $error("mem_port_arbiter: unsupported parameter values");
  end
  state_t            state, state_n;
  owner_t            owner;
  logic              we_q, flushed, ovr, open, acc, issue, resp;
  logic [ADDR_W-3:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [3:0]        wstrb_q;
  logic [2:0]        cnt;
`ifdef MEM_ARB_STARVE_EN
  mem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk(clk),
    .rst(rst),
    .d_grant(bus.d_req_ready),
    .if_grant(bus.if_req_ready),
    .if_valid(bus.if_req_valid),
    .override(ovr)
  );
`else
  assign ovr = 1'b0;
`endif
  assign open = (state == IDLE || state == RESP) && !rst;
  assign bus.d_req_ready = open && bus.d_req_valid && !(bus.if_req_valid && ovr);
  assign bus.if_req_ready = open && bus.if_req_valid && !(bus.d_req_valid && !ovr);
  assign acc = bus.d_req_ready || bus.if_req_ready;
  assign issue = state == ISSUE;
  assign resp = state == RESP;
  always_comb begin
    state_n = issue ? WAIT : (state == WAIT) ? (cnt == 3'd1 ? RESP : WAIT) : (acc ? ISSUE : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= OWN_IF;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      cnt <= '0;
      flushed <= 1'b0;
    end else begin
      if (acc) begin
        owner <= bus.d_req_ready ? OWN_D : OWN_IF;
        we_q <= bus.d_req_ready && bus.d_we;
        addr_q <= bus.d_req_ready ? bus.d_addr[ADDR_W-1:2] : bus.if_addr[ADDR_W-1:2];
        wdata_q <= bus.d_req_ready ? bus.d_wdata : '0;
        wstrb_q <= bus.d_req_ready ? bus.d_wstrb : '0;
        flushed <= 1'b0;
      end else if (bus.if_flush && owner == OWN_IF && (issue || state == WAIT)) begin
        flushed <= 1'b1;
      end
      cnt <= issue ? 3'(MEM_LAT) : (state == WAIT) ? cnt - 3'd1 : 3'd0;
      if (state == WAIT && cnt == 3'd1) rdata_q <= we_q ? '0 : bus.mem_rdata;
    end
  end
  assign bus.if_rsp_valid = resp && owner == OWN_IF && !flushed && !bus.if_flush;
  assign bus.if_rdata = bus.if_rsp_valid ? rdata_q : '0;
  assign bus.d_rsp_valid = resp && owner == OWN_D;
  assign bus.d_rdata = bus.d_rsp_valid ? rdata_q : '0;
  assign bus.mem_en = issue;
  assign bus.mem_we = issue && we_q;
  assign bus.mem_addr = issue ? addr_q : '0;
  assign bus.mem_wdata = issue ? wdata_q : '0;
  assign bus.mem_wstrb = issue ? wstrb_q : '0;
endmodule
